// File: rtl/confreg_pkg.sv
// confreg_pkg: register offsets, widths, reset values and the byte-lane
// merge helper shared by the configuration-register responder.
package confreg_pkg;

    // Register offsets within the 64 KiB window (addr[1:0] masked off)
    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_LED_RG0 = 16'hF004;
    localparam logic [15:0] OFF_LED_RG1 = 16'hF008;
    localparam logic [15:0] OFF_NUM     = 16'hF010;
    localparam logic [15:0] OFF_SWITCH  = 16'hF020;
    localparam logic [15:0] OFF_BTN     = 16'hF024;
    localparam logic [15:0] OFF_SIMU    = 16'hF030;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;

    // Register widths
    localparam int LED_W    = 16;
    localparam int LED_RG_W = 2;
    localparam int NUM_W    = 32;
    localparam int SWITCH_W = 8;
    localparam int BTN_W    = 16;
    localparam int TIMER_W  = 32;

    // Reset values
    localparam logic [LED_W-1:0]    LED_RST    = '0;
    localparam logic [LED_RG_W-1:0] LED_RG_RST = '0;
    localparam logic [NUM_W-1:0]    NUM_RST    = '0;
    localparam logic [SWITCH_W-1:0] SWITCH_RST = '0;
    localparam logic [BTN_W-1:0]    BTN_RST    = '0;
    localparam logic [TIMER_W-1:0]  TIMER_RST  = '0;
    localparam logic [31:0]         RDATA_RST  = '0;

    // Replace each byte of cur whose write enable is set with the matching
    // byte of wdata; untouched lanes keep the current value.
    function automatic logic [31:0] mergeBytes(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/confreg_resp_if.sv
// confreg_resp_if: SRAM-style data-port bundle between the CPU core
// (master) and the configuration-register responder (slave).
interface confreg_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/confreg_timer.sv
// confreg_timer: free-running 32-bit counter with a byte-merge write port.
// A write replaces the increment for that cycle; unwritten lanes keep the
// pre-increment value.
module confreg_timer
    import confreg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wrEn,
    input  logic [3:0]         wen,
    input  logic [31:0]        wdata,
    output logic [TIMER_W-1:0] count
);

    // Counter: reset, else write-over-increment, else count up with wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= TIMER_RST;
        end else if (wrEn) begin
            count <= mergeBytes(count, wdata, wen);
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/confreg_resp.sv
// confreg_resp: memory-mapped configuration-register responder on the CPU
// data port. Serves LED, bicolour LED, seven-segment, switch, button and
// simulation-flag registers with one-cycle registered reads.
// Optional feature macro: CONFREG_TIMER_EN adds the free-running TIMER
// register at offset E000; without it E000 reads 0 and ignores writes.
module confreg_resp
    import confreg_pkg::*;
#(
    parameter logic [15:0] BASE_HI   = 16'hBFAF,
    parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    confreg_resp_if.slave       bus,
    output logic [LED_W-1:0]    led,
    output logic [LED_RG_W-1:0] led_rg0,
    output logic [LED_RG_W-1:0] led_rg1,
    output logic [NUM_W-1:0]    num_data,
    input  logic [SWITCH_W-1:0] switch_in,
    input  logic [BTN_W-1:0]    btn_in
);

    logic                sel;
    logic                wrReq;
    logic                rdReq;
    logic [15:0]         offset;
    logic [31:0]         rdNext;
    logic [31:0]         merged;
    logic [SWITCH_W-1:0] switchMeta;
    logic [SWITCH_W-1:0] switchSync;
    logic [BTN_W-1:0]    btnMeta;
    logic [BTN_W-1:0]    btnSync;

    assign sel    = bus.en & (bus.addr[31:16] == BASE_HI);
    assign offset = bus.addr[15:0] & 16'hFFFC;
    assign wrReq  = sel & (|bus.wen);
    assign rdReq  = sel & (bus.wen == 4'b0000);

`ifdef CONFREG_TIMER_EN
    logic [TIMER_W-1:0] timerVal;
    logic               timerWr;

    assign timerWr = wrReq & (offset == OFF_TIMER);

    confreg_timer uTimer (
        .clk   (clk),
        .reset (reset),
        .wrEn  (timerWr),
        .wen   (bus.wen),
        .wdata (bus.wdata),
        .count (timerVal)
    );
`endif

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            switchMeta <= SWITCH_RST;
            switchSync <= SWITCH_RST;
            btnMeta    <= BTN_RST;
            btnSync    <= BTN_RST;
        end else begin
            switchMeta <= switch_in;
            switchSync <= switchMeta;
            btnMeta    <= btn_in;
            btnSync    <= btnMeta;
        end
    end

    // Read mux: zero-extended current value of the addressed register
    always_comb begin
        rdNext = '0;
        case (offset)
            OFF_LED:     rdNext = {16'h0000, led};
            OFF_LED_RG0: rdNext = {30'h0, led_rg0};
            OFF_LED_RG1: rdNext = {30'h0, led_rg1};
            OFF_NUM:     rdNext = num_data;
            OFF_SWITCH:  rdNext = {24'h00_0000, switchSync};
            OFF_BTN:     rdNext = {16'h0000, btnSync};
            OFF_SIMU:    rdNext = SIMU_FLAG;
`ifdef CONFREG_TIMER_EN
            OFF_TIMER:   rdNext = timerVal;
`endif
            default:     rdNext = '0;
        endcase
    end

    // The merge base is the addressed register's current value, so
    // narrow registers simply keep the low bits of the merged word.
    assign merged = mergeBytes(rdNext, bus.wdata, bus.wen);

    // Writable board registers; RO and unmapped offsets fall through
    always_ff @(posedge clk) begin
        if (reset) begin
            led      <= LED_RST;
            led_rg0  <= LED_RG_RST;
            led_rg1  <= LED_RG_RST;
            num_data <= NUM_RST;
        end else if (wrReq) begin
            case (offset)
                OFF_LED:     led      <= merged[15:0];
                OFF_LED_RG0: led_rg0  <= merged[1:0];
                OFF_LED_RG1: led_rg1  <= merged[1:0];
                OFF_NUM:     num_data <= merged;
                default:     ;
            endcase
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rdata <= RDATA_RST;
        end else if (rdReq) begin
            bus.rdata <= rdNext;
        end
    end

endmodule

// File: tb/tb_confreg_resp.sv
// tb_confreg_resp: directed test-plan sequences followed by randomized
// traffic, all checked against a behavioural model of the register map.
module tb_confreg_resp;

    localparam logic [15:0] BASE = 16'hBFAF;
    localparam logic [31:0] SIMU = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  switchIn;
    logic [15:0] btnIn;
    logic [15:0] led;
    logic [1:0]  ledRg0;
    logic [1:0]  ledRg1;
    logic [31:0] numData;

    confreg_resp_if bus ();

    confreg_resp #(.BASE_HI(BASE), .SIMU_FLAG(SIMU)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .led       (led),
        .led_rg0   (ledRg0),
        .led_rg1   (ledRg1),
        .num_data  (numData),
        .switch_in (switchIn),
        .btn_in    (btnIn)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Behavioural model state
    logic [15:0] mLed   = '0;
    logic [1:0]  mRg0   = '0;
    logic [1:0]  mRg1   = '0;
    logic [31:0] mNum   = '0;
    logic [31:0] mRdata = '0;
    logic [31:0] tBase  = '0;  // timer value loaded at edge tLoad
    logic [31:0] tLoad  = '0;
    logic [31:0] nEdges = '0;
    logic [7:0]  swHist[$]  = '{8'h00, 8'h00};   // samples from two edges back, one edge back
    logic [15:0] btnHist[$] = '{16'h0000, 16'h0000};

    // Apply whatever is on the inputs to one clock edge, advance the model,
    // then compare all outputs just after the edge.
    task automatic tick();
        logic        sel;
        logic [15:0] off;
        logic [31:0] cur;
        logic [31:0] rv;
        logic [31:0] mg;
        sel = bus.en && (bus.addr[31:16] == BASE);
        off = bus.addr[15:0] & 16'hFFFC;
        cur = tBase + (nEdges - tLoad);
        rv  = 32'h0;
        case (off)
            16'hF000: rv = {16'h0, mLed};
            16'hF004: rv = {30'h0, mRg0};
            16'hF008: rv = {30'h0, mRg1};
            16'hF010: rv = mNum;
            16'hF020: rv = {24'h0, swHist[0]};
            16'hF024: rv = {16'h0, btnHist[0]};
            16'hF030: rv = SIMU;
`ifdef CONFREG_TIMER_EN
            16'hE000: rv = cur;
`endif
            default:  rv = 32'h0;
        endcase
        mg = rv;
        for (int i = 0; i < 4; i++)
            if (bus.wen[i]) mg[8*i +: 8] = bus.wdata[8*i +: 8];
        @(posedge clk);
        nEdges = nEdges + 1;
        void'(swHist.pop_front());
        swHist.push_back(switchIn);
        void'(btnHist.pop_front());
        btnHist.push_back(btnIn);
        if (reset) begin
            mLed = '0; mRg0 = '0; mRg1 = '0; mNum = '0; mRdata = '0;
            tBase = '0; tLoad = nEdges;
            swHist  = '{8'h00, 8'h00};
            btnHist = '{16'h0000, 16'h0000};
        end else if (sel) begin
            if (bus.wen == 4'b0000) begin
                mRdata = rv;
            end else begin
                case (off)
                    16'hF000: mLed = mg[15:0];
                    16'hF004: mRg0 = mg[1:0];
                    16'hF008: mRg1 = mg[1:0];
                    16'hF010: mNum = mg;
`ifdef CONFREG_TIMER_EN
                    16'hE000: begin tBase = mg; tLoad = nEdges; end
`endif
                    default: ;
                endcase
            end
        end
        #1;
        chk("rdata",   bus.rdata,       mRdata);
        chk("led",     {16'h0, led},    {16'h0, mLed});
        chk("led_rg0", {30'h0, ledRg0}, {30'h0, mRg0});
        chk("led_rg1", {30'h0, ledRg1}, {30'h0, mRg1});
        chk("num",     numData,         mNum);
    endtask

    task automatic op(input logic e, input logic [3:0] w, input logic [15:0] off, input logic [31:0] d);
        bus.en = e; bus.wen = w; bus.addr = {BASE, off}; bus.wdata = d;
        tick();
    endtask

    task automatic idle();
        op(1'b0, 4'h0, 16'h0000, 32'h0);
    endtask

    logic [15:0] offs[10] = '{16'hF000, 16'hF004, 16'hF008, 16'hF010, 16'hF020,
                              16'hF024, 16'hF030, 16'hE000, 16'hF100, 16'hF00C};

    initial begin
        reset = 1'b1; switchIn = 8'h00; btnIn = 16'h0000;
        bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;

        // Reset state
        tick();
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        reset = 1'b0;

        // Reads right after reset
        op(1'b1, 4'h0, 16'hE000, 32'h0);
        chk("timer_first", bus.rdata, 32'h0);
        op(1'b1, 4'h0, 16'hF000, 32'h0);
        chk("led_rd0", bus.rdata, 32'h0);
        op(1'b1, 4'h0, 16'hF010, 32'h0);
        chk("num_rd0", bus.rdata, 32'h0);
        op(1'b1, 4'h0, 16'hE000, 32'h0);
`ifdef CONFREG_TIMER_EN
        chk("timer_nz", {31'h0, bus.rdata != 32'h0}, 32'h1);
`else
        chk("timer_off", bus.rdata, 32'h0);
`endif

        // LED byte-lane writes
        op(1'b1, 4'b0011, 16'hF000, 32'h1234_ABCD);
        op(1'b1, 4'b0000, 16'hF000, 32'h0);
        chk("led_abcd", {16'h0, led}, 32'h0000_ABCD);
        chk("led_rd", bus.rdata, 32'h0000_ABCD);
        op(1'b1, 4'b0010, 16'hF000, 32'h0000_5500);
        chk("led_55cd", {16'h0, led}, 32'h0000_55CD);

        // Timer wrap and write-over-increment
        op(1'b1, 4'hF, 16'hE000, 32'hFFFF_FFFE);
        idle(); idle();
        op(1'b1, 4'h0, 16'hE000, 32'h0);
        chk("timer_wrap", bus.rdata, 32'h0);
        op(1'b1, 4'b0001, 16'hE000, 32'h0000_0010);
        op(1'b1, 4'h0, 16'hE000, 32'h0);
`ifdef CONFREG_TIMER_EN
        chk("timer_wr", bus.rdata, 32'h0000_0010);
`else
        chk("timer_wr", bus.rdata, 32'h0);
`endif
        idle(); idle(); idle();
        op(1'b1, 4'h0, 16'hE000, 32'h0);
`ifdef CONFREG_TIMER_EN
        chk("timer_run", bus.rdata, 32'h0000_0014);
`else
        chk("timer_run", bus.rdata, 32'h0);
`endif

        // Switch synchronizer latency
        switchIn = 8'hA5;
        idle();
        op(1'b1, 4'h0, 16'hF020, 32'h0);
        chk("sw_old", bus.rdata, 32'h0);
        op(1'b1, 4'h0, 16'hF020, 32'h0);
        chk("sw_new", bus.rdata, 32'h0000_00A5);

        // RO / unmapped writes, foreign base
        op(1'b1, 4'hF, 16'hF020, 32'hFFFF_FFFF);
        op(1'b1, 4'hF, 16'hF030, 32'hFFFF_FFFF);
        op(1'b1, 4'hF, 16'hF100, 32'hFFFF_FFFF);
        op(1'b1, 4'h0, 16'hF020, 32'h0);
        chk("sw_ro", bus.rdata, 32'h0000_00A5);
        op(1'b1, 4'h0, 16'hF100, 32'h0);
        chk("unmapped", bus.rdata, 32'h0);
        op(1'b1, 4'h0, 16'hF030, 32'h0);
        chk("simu", bus.rdata, SIMU);
        bus.en = 1'b1; bus.wen = 4'h0; bus.addr = 32'h1234_F000; bus.wdata = 32'h0;
        tick();
        chk("foreign_rd", bus.rdata, SIMU);
        bus.wen = 4'hF; bus.wdata = 32'hFFFF_FFFF;
        tick();
        chk("foreign_wr", {16'h0, led}, 32'h0000_55CD);

        // Reset overrides a concurrent write
        op(1'b1, 4'hF, 16'hF010, 32'h1122_3344);
        chk("num_wr", numData, 32'h1122_3344);
        reset = 1'b1;
        op(1'b1, 4'hF, 16'hF010, 32'hDEAD_BEEF);
        reset = 1'b0;
        chk("rst_num", numData, 32'h0);
        chk("rst_rd", bus.rdata, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) switchIn = 8'($urandom);
            if ($urandom_range(0, 7) == 0) btnIn = 16'($urandom);
            bus.en    = ($urandom_range(0, 9) < 8);
            bus.wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            bus.addr  = {($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE,
                         offs[$urandom_range(0, 9)] | 16'($urandom_range(0, 3))};
            bus.wdata = $urandom;
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
